// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush controller.
// Optional perf counters are enabled with PIPE_STALL_PERF_EN.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [1:0] SR_NONE   = 2'd0;
  localparam logic [1:0] SR_MEM    = 2'd1;
  localparam logic [1:0] SR_HILO   = 2'd2;
  localparam logic [1:0] SR_HAZARD = 2'd3;

  localparam int MULT_LAT_DEF = 4;
  localparam int DIV_LAT_DEF  = 32;

endpackage

// File: rtl/muldiv_latency_counter.sv
// Load/decrement latency counter for the mult/div unit.
// done_o flags the final busy cycle (count of one).
module muldiv_latency_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/pipeline_stall_controller.sv
// Prioritised stall/flush sequencer and mult/div busy FSM.
// Perf counters are enabled with PIPE_STALL_PERF_EN.
module pipeline_stall_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
`ifdef PIPE_STALL_PERF_EN
  parameter int PERF_W   = 32,
`endif
  parameter int CNT_W    = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hazard_stall,
  input  logic             mem_wait,
  input  logic             muldiv_start,
  input  logic             muldiv_is_div,
  input  logic             id_hilo_use,
  input  logic             branch_taken,
  input  logic             jump,
  output logic             pc_freeze,
  output logic             IF_ID_freeze,
  output logic             IF_ID_flush,
  output logic             control_flush,
  output logic             ID_EX_freeze,
  output logic             EX_MEM_freeze,
  output logic             MEM_WB_flush,
  output logic             muldiv_busy,
  output logic             muldiv_done,
`ifdef PIPE_STALL_PERF_EN
  output logic [PERF_W-1:0] perf_stall_cycles,
  output logic [PERF_W-1:0] perf_mem_cycles,
  output logic [PERF_W-1:0] perf_flush_count,
`endif
  output logic [1:0]       stall_reason
);

  state_e state_q;
  logic   busy, cnt_done, done, accept, hilo_stall;
  logic [CNT_W-1:0] lat;

  assign busy   = (state_q == BUSY);
  assign done   = busy & cnt_done;
  assign accept = (state_q == RUN) & muldiv_start & ~mem_wait;
  assign lat    = muldiv_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);

  muldiv_latency_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (accept),
    .load_val_i (lat),
    .dec_i      (busy),
    .done_o     (cnt_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      unique case (state_q)
        RUN:  if (accept) state_q <= BUSY;
        BUSY: if (done)   state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  // HI/LO is forwarded in the done cycle, so the reader is released there.
  assign hilo_stall = busy & id_hilo_use & ~done;

  always_comb begin
    pc_freeze     = 1'b0;
    IF_ID_freeze  = 1'b0;
    IF_ID_flush   = 1'b0;
    control_flush = 1'b0;
    ID_EX_freeze  = 1'b0;
    EX_MEM_freeze = 1'b0;
    MEM_WB_flush  = 1'b0;
    stall_reason  = SR_NONE;
    if (reset) begin
      stall_reason = SR_NONE;
    end else if (mem_wait) begin
      pc_freeze     = 1'b1;
      IF_ID_freeze  = 1'b1;
      ID_EX_freeze  = 1'b1;
      EX_MEM_freeze = 1'b1;
      MEM_WB_flush  = 1'b1;
      stall_reason  = SR_MEM;
    end else if (hilo_stall || hazard_stall) begin
      pc_freeze     = 1'b1;
      IF_ID_freeze  = 1'b1;
      control_flush = 1'b1;
      stall_reason  = hilo_stall ? SR_HILO : SR_HAZARD;
    end else if (branch_taken || jump) begin
      IF_ID_flush   = 1'b1;
    end
  end

  assign muldiv_busy = busy & ~reset;
  assign muldiv_done = done & ~reset;

  ap_no_start_busy: assert property (
    @(posedge clk) disable iff (reset) busy |-> !muldiv_start);

`ifdef PIPE_STALL_PERF_EN
  logic [PERF_W-1:0] stall_q, mem_q, flush_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      mem_q   <= '0;
      flush_q <= '0;
    end else begin
      if (stall_reason != SR_NONE && ~&stall_q) stall_q <= stall_q + 1'b1;
      if (stall_reason == SR_MEM && ~&mem_q)    mem_q   <= mem_q + 1'b1;
      if (IF_ID_flush && ~&flush_q)             flush_q <= flush_q + 1'b1;
    end
  end

  assign perf_stall_cycles = stall_q;
  assign perf_mem_cycles   = mem_q;
  assign perf_flush_count  = flush_q;
`endif

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Merges four sources: the load-use/RAW stall from the hazard detection unit, data-memory wait, multi-cycle mult/div occupancy, and branch/jump redirects.
- Produces one prioritised set of freeze/flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Owns the mult/div busy FSM and latency counter.

Parameters:
- MULT_LAT, 4, cycles a mult/multu occupies HI/LO (>=1)
- DIV_LAT, 32, cycles a div/divu occupies HI/LO (>=1)
- CNT_W, 6, latency counter width; must satisfy 2^CNT_W > max(MULT_LAT, DIV_LAT)
- PERF_W, 32, width of performance counters (optional feature only)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- hazard_stall  input  1  load-use/RAW stall request from hazard detection unit
- mem_wait  input  1  data memory not ready; whole pipeline must hold
- muldiv_start  input  1  EX-stage mult/div issuing this cycle
- muldiv_is_div  input  1  qualifies muldiv_start: 1=div latency, 0=mult latency
- id_hilo_use  input  1  ID-stage instruction reads/writes HI/LO (mfhi/mflo/mthi/mtlo/mult/div)
- branch_taken  input  1  ID-resolved taken branch
- jump  input  1  ID-stage j/jal/jr
- pc_freeze  output  1  hold PC
- IF_ID_freeze  output  1  hold IF/ID
- IF_ID_flush  output  1  zero IF/ID (squash fetched instruction)
- control_flush  output  1  insert bubble into ID/EX
- ID_EX_freeze  output  1  hold ID/EX
- EX_MEM_freeze  output  1  hold EX/MEM
- MEM_WB_flush  output  1  bubble into MEM/WB
- muldiv_busy  output  1  FSM in BUSY
- muldiv_done  output  1  one-cycle pulse, final busy cycle
- stall_reason  output  2  0 none, 1 mem_wait, 2 hilo, 3 hazard

Behaviour:
- State: FSM {RUN, BUSY} plus CNT_W-bit down-counter cnt.
- Reset: while reset=1, all outputs are 0 in that cycle. On the next edge: state=RUN, cnt=0.
- Reset mid-BUSY aborts the operation with no muldiv_done pulse.
- Acceptance:
  - In RUN, muldiv_start=1 and mem_wait=0 at edge t gives state=BUSY and cnt=(muldiv_is_div ? DIV_LAT : MULT_LAT).
  - In RUN with mem_wait=1, muldiv_start is not accepted; the instruction is held in EX and re-presented.
- BUSY:
  - cnt decrements every cycle, including during mem_wait, because the unit runs independently.
  - When cnt==1: muldiv_done=1 and next state=RUN.
  - BUSY therefore lasts exactly LAT cycles, t+1..t+LAT. LAT=1 gives a single BUSY cycle with done.
  - muldiv_start while BUSY cannot occur (ID is stalled); the implementation ignores it and carries an assertion.
- Control outputs: combinational from state, cnt and inputs, evaluated in priority order:
  1. mem_wait=1: pc_freeze=IF_ID_freeze=ID_EX_freeze=EX_MEM_freeze=MEM_WB_flush=1; stall_reason=1. Branch/jump suppressed.
  2. (BUSY & id_hilo_use & !muldiv_done) or hazard_stall: pc_freeze=IF_ID_freeze=control_flush=1; stall_reason=2 if the hilo term is true, else 3. Branch/jump suppressed; the instruction stays in ID and the redirect is re-evaluated next cycle.
  3. branch_taken|jump: IF_ID_flush=1 only.
  4. Otherwise: all controls 0, stall_reason=0.
- In the muldiv_done cycle, an id_hilo_use instruction is released (HI/LO valid via forwarding).
- Freeze and flush of the same register are never asserted together.
- muldiv_busy = (state==BUSY).

Optional Feature:
- Macro: PIPE_STALL_PERF_EN.
- Defined: adds outputs perf_stall_cycles, perf_mem_cycles and perf_flush_count (each PERF_W).
  - Incremented per cycle with stall_reason!=0, stall_reason==1, and IF_ID_flush=1 respectively.
  - Saturating at all-ones; cleared by reset.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Package pipe_ctrl_pkg:
  - state encoding (RUN=0, BUSY=1)
  - stall_reason codes
  - default MULT_LAT/DIV_LAT constants
- Sub-module muldiv_latency_counter:
  - load/decrement counter with done flag
  - instantiated once; the FSM stays in the top level.

Test Plan:
- Reset held 3 cycles with hazard_stall=1 -> all outputs 0; after release, state RUN and pc_freeze follows hazard_stall.
- muldiv_start, muldiv_is_div=0 at cycle 10 with MULT_LAT=4 -> muldiv_busy cycles 11-14, muldiv_done only at 14; id_hilo_use=1 throughout gives pc_freeze/control_flush at 11-13, released at 14, stall_reason=2.
- DIV_LAT=32 div with mem_wait=1 during cycles 15-20 -> done still at cycle 32 after start; stall_reason=1 and EX_MEM_freeze=1 during 15-20.
- hazard_stall=1 and branch_taken=1 same cycle -> IF_ID_flush=0, control_flush=1; next cycle hazard_stall=0 -> IF_ID_flush=1.
- mem_wait=1 with hazard_stall=1 and jump=1 -> only the priority-1 set asserted, stall_reason=1.
- PIPE_STALL_PERF_EN defined with 5 stall cycles and 2 flushes -> perf_stall_cycles=5, perf_flush_count=2; preloaded near all-ones the counters saturate without wrapping.
